innerproduct_mac: RTL and testbench
===================================

# innerproduct_mac

Sequential, parametrised inner-product engine for the linebuffer logistic-regression path. It computes hprime = Σ x[k]·θ[k] over N_FEAT features. Features stream in as LANES features per beat over a valid/ready handshake, and θ lives in a runtime-loadable coefficient register file. The result is a saturating, signed accumulator value. It sits between the linebuffer window extractor and the sigmoid/threshold stage, and replaces the fixed 81-term combinational product with a pipelined, lane-parallel datapath.

## Interface
Parameters:
- N_FEAT, 81: features per vector.
- LANES, 9: features per input beat. N_FEAT % LANES == 0 is required; an elaboration-time check enforces it.
- X_W, 7: feature width, unsigned.
- THETA_W, 16: coefficient width, signed two's complement.
- ACC_W, 32: accumulator/result width, signed.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- theta_we  in  1  coefficient write strobe.
- theta_addr  in  $clog2(N_FEAT)  coefficient index.
- theta_data  in  THETA_W  coefficient value.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  engine accepts a beat.
- in_data  in  LANES*X_W  lane l occupies bits [l*X_W +: X_W], feature index = beat*LANES + l.
- in_last  in  1  marks the final beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- hprime  out  ACC_W  signed inner product.
- sat  out  1  the accumulation saturated during this vector.
- frame_err  out  1  in_last did not coincide with beat N_FEAT/LANES-1.

## Operation
- The FSM has four states: IDLE, ACCUM, DRAIN, HOLD.
- IDLE:
  - in_ready=1.
  - theta_we is honoured only in IDLE. A write updates θ[theta_addr] at the clock edge; addr ≥ N_FEAT is ignored.
  - The first accepted beat clears acc/sat/frame_err, sets beat=1, and moves to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each accepted beat increments beat.
  - The vector ends when beat index NB-1 is accepted (NB = N_FEAT/LANES) or when in_last is accepted, whichever comes first. Either moves to DRAIN.
  - frame_err=1 if in_last and the final-index condition disagree. The vector still ends, and missing lanes contribute 0.
- DRAIN:
  - in_ready=0.
  - Waits for the 2-stage pipeline to empty, then moves to HOLD.
- HOLD:
  - out_valid=1. hprime, sat and frame_err are stable.
  - out_valid&&out_ready returns to IDLE.
  - in_ready=0 until that handshake completes.
- Pipeline:
  - Stage 1 registers LANES products p[l] = $signed({1'b0,x[l]}) * θ[beat*LANES+l], each X_W+1+THETA_W bits.
  - Stage 2 sums the products sign-extended to ACC_W+$clog2(LANES)+1 bits, adds the result to acc, then saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Saturation sets sat, which is sticky for the vector.
- θ is read with the beat index captured at acceptance, so a stalled in_valid never misaligns coefficients.

## Timing
- Reset values: in_ready=1, out_valid=0, hprime=0, sat=0, frame_err=0. State goes to IDLE and the pipeline valids clear. θ resets to all zeros.
- A beat is accepted on in_valid&&in_ready at a rising edge.
- Latency: the final beat is accepted at edge t, and out_valid rises after edge t+2. With out_ready held high, out_valid stays high for 1 cycle.
- Minimum vector period is NB+3 cycles: NB beats, 2 drain cycles, 1 output handshake.
- Input bubbles (in_valid=0 in ACCUM) are allowed at any beat and do not change the result.
- When theta_we fires in IDLE on the same edge as the first beat is accepted, the write lands first. The beat uses the new θ only if the address is ≥ LANES; otherwise the old value is used. Benches must not rely on this case.
- rst asserted mid-vector aborts immediately. No output is produced and all reset values apply, including θ.
- Back-pressure on out_ready holds hprime indefinitely with no loss.

## Structure
- Package innerproduct_pkg holds the state enum (IDLE/ACCUM/DRAIN/HOLD), the saturating-add function sat_add(acc, sum) and the default parameter constants.
- One sub-module, lane_sum_tree: a registered LANES-input signed adder. It yields the stage-2 sum.
- The θ register file and FSM stay in the top.
- Target size is 200–300 lines total.

## Test plan
- **Load and single vector:** Load θ[k]=1 for all k, stream 9 beats of x=127 with in_last on beat 8 -> hprime=10287, sat=0, frame_err=0, out_valid 2 cycles after the last beat.
- **Signed coefficients and bubbles:** θ[k]=-3 for even k and 2 for odd k, x[k]=k%128, random in_valid gaps -> hprime equals the software golden value. The result is identical with and without gaps.
- **Saturation:** θ=32767 everywhere, x=127, ACC_W=24 -> hprime=8388607, sat=1. Flip θ to -32768 -> hprime=-8388608, sat=1.
- **Framing error:** in_last on beat 5 -> vector ends after 6 beats, frame_err=1, and hprime sums only features 0–53. A mid-stream extra beat with no in_last at beat 8 -> the vector ends at beat 8 and frame_err=1.
- **Back-pressure and ignored writes:** hold out_ready=0 for 20 cycles -> hprime stable, in_ready=0. A theta_we issued during ACCUM/HOLD leaves θ unchanged, as checked by the next vector.
- **Reset mid-operation:** assert rst at beat 4 -> out_valid never rises and all outputs return to reset values. θ=0 afterwards, so the next vector gives hprime=0.

Source files
------------

// File: rtl/innerproduct_pkg.sv
// Shared definitions for the lane-parallel inner-product engine: default sizes,
// FSM state encoding and the saturating accumulate helper.
package innerproduct_pkg;

  localparam int N_FEAT_DEF  = 81;
  localparam int LANES_DEF   = 9;
  localparam int X_W_DEF     = 7;
  localparam int THETA_W_DEF = 16;
  localparam int ACC_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Adds sum to acc and clamps the result to the signed acc_w-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] sum,
                                                 input int acc_w);
    logic signed [63:0] total;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    total = acc + sum;
    hi    = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (acc_w - 1));
    if (total > hi) begin
      return hi;
    end else if (total < lo) begin
      return lo;
    end else begin
      return total;
    end
  endfunction

endpackage

// File: rtl/innerproduct_mac_lane_sum_tree.sv
// Registered LANES-input signed adder: sign-extends each lane product and
// presents the lane total one cycle after its products arrive.
module lane_sum_tree
  import innerproduct_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int P_W   = 24,
  parameter int SUM_W = 37
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANES*P_W-1:0]    prod,
  output logic signed [SUM_W-1:0] sum,
  output logic                    sum_valid
);

  logic signed [SUM_W-1:0] sum_s;

  // Combinational tree over all lanes, each product sign-extended first.
  always_comb begin
    sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_s = sum_s + {{(SUM_W - P_W){prod[l*P_W + P_W - 1]}}, prod[l*P_W +: P_W]};
    end
  end

  // Register the lane total together with its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= in_valid;
      if (in_valid) begin
        sum <= sum_s;
      end
    end
  end

endmodule

// File: rtl/innerproduct_mac.sv
// Sequential inner product hprime = sum x[k]*theta[k], fed LANES features per
// beat, with a runtime-loadable coefficient file and a saturating accumulator.
module innerproduct_mac
  import innerproduct_pkg::*;
#(
  parameter int N_FEAT  = N_FEAT_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int THETA_W = THETA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       theta_we,
  input  logic [$clog2(N_FEAT)-1:0]  theta_addr,
  input  logic [THETA_W-1:0]         theta_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*X_W-1:0]       in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    hprime,
  output logic                       sat,
  output logic                       frame_err
);

  localparam int NB    = N_FEAT / LANES;
  localparam int A_W   = $clog2(N_FEAT);
  localparam int B_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int P_W   = X_W + 1 + THETA_W;
  localparam int SUM_W = ACC_W + $clog2(LANES) + 1;

  if (N_FEAT % LANES != 0) begin : g_lanes_check
    $error("innerproduct_mac: N_FEAT must be a multiple of LANES");
  end

  state_t                   state_r;
  logic [B_W-1:0]           beat_r;
  logic [B_W-1:0]           idx_s;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic                     sat_r;
  logic                     frame_err_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [THETA_W-1:0] theta_r [N_FEAT];
  logic signed [THETA_W-1:0] theta_sel_s [LANES];
  logic signed [P_W-1:0]    prod_r [LANES];
  logic [LANES*P_W-1:0]     prod_flat_s;
  logic                     prod_valid_r;
  logic signed [SUM_W-1:0]  sum_s;
  logic                     sum_valid_s;
  logic                     accept_s;
  logic                     is_final_s;
  logic                     end_s;
  logic signed [63:0]       acc_ext_s;
  logic signed [63:0]       sum_ext_s;
  logic signed [63:0]       total_s;
  logic signed [63:0]       clamp_s;

  assign accept_s   = in_valid && in_ready_r;
  assign idx_s      = (state_r == IDLE) ? '0 : beat_r;
  assign is_final_s = (idx_s == B_W'(NB - 1));
  assign end_s      = is_final_s || in_last;

  // Coefficients for the beat on the bus, indexed by its own beat number.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      theta_sel_s[l] = theta_r[A_W'(int'(idx_s) * LANES + l)];
    end
  end

  // Coefficient register file; writes land only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_FEAT; k++) begin
        theta_r[k] <= '0;
      end
    end else if (theta_we && (state_r == IDLE) && (32'(theta_addr) < N_FEAT)) begin
      theta_r[theta_addr] <= theta_data;
    end
  end

  // Stage 1: one signed product per lane, captured with the accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_valid_r <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        prod_r[l] <= '0;
      end
    end else begin
      prod_valid_r <= accept_s;
      if (accept_s) begin
        for (int l = 0; l < LANES; l++) begin
          prod_r[l] <= $signed({1'b0, in_data[l*X_W +: X_W]}) * theta_sel_s[l];
        end
      end
    end
  end

  // Flatten the product registers for the adder tree.
  always_comb begin
    prod_flat_s = '0;
    for (int l = 0; l < LANES; l++) begin
      prod_flat_s[l*P_W +: P_W] = prod_r[l];
    end
  end

  lane_sum_tree #(
    .LANES (LANES),
    .P_W   (P_W),
    .SUM_W (SUM_W)
  ) u_lane_sum_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (prod_valid_r),
    .prod      (prod_flat_s),
    .sum       (sum_s),
    .sum_valid (sum_valid_s)
  );

  assign acc_ext_s = {{(64 - ACC_W){acc_r[ACC_W-1]}}, acc_r};
  assign sum_ext_s = {{(64 - SUM_W){sum_s[SUM_W-1]}}, sum_s};
  assign total_s   = acc_ext_s + sum_ext_s;
  assign clamp_s   = sat_add(acc_ext_s, sum_ext_s, ACC_W);

  // Control FSM with registered handshake outputs and the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      acc_r       <= '0;
      sat_r       <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (sum_valid_s) begin
        acc_r <= clamp_s[ACC_W-1:0];
        sat_r <= sat_r | (clamp_s != total_s);
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // A new vector starts clean; the pipeline is empty here.
            acc_r       <= '0;
            sat_r       <= 1'b0;
            frame_err_r <= end_s ? (in_last != is_final_s) : 1'b0;
            beat_r      <= idx_s + B_W'(1);
            state_r     <= end_s ? DRAIN : ACCUM;
            in_ready_r  <= !end_s;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            beat_r <= idx_s + B_W'(1);
            if (end_s) begin
              frame_err_r <= (in_last != is_final_s);
              state_r     <= DRAIN;
              in_ready_r  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!prod_valid_r && sum_valid_s) begin
            state_r     <= HOLD;
            out_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign hprime    = acc_r;
  assign sat       = sat_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_innerproduct_mac.sv
// Directed self-checking bench for innerproduct_mac (ACC_W=24 so saturation
// is reachable with 7-bit features and 16-bit coefficients).
module tb_innerproduct_mac;

  localparam int N_FEAT  = 81;
  localparam int LANES   = 9;
  localparam int X_W     = 7;
  localparam int THETA_W = 16;
  localparam int ACC_W   = 24;
  localparam int A_W     = $clog2(N_FEAT);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     theta_we;
  logic [A_W-1:0]           theta_addr;
  logic [THETA_W-1:0]       theta_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*X_W-1:0]     in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  hprime;
  logic                     sat;
  logic                     frame_err;

  int n_checks = 0;
  int n_errors = 0;

  innerproduct_mac #(
    .N_FEAT  (N_FEAT),
    .LANES   (LANES),
    .X_W     (X_W),
    .THETA_W (THETA_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .theta_we   (theta_we),
    .theta_addr (theta_addr),
    .theta_data (theta_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hprime     (hprime),
    .sat        (sat),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: every feature is 127; mode 1: feature k is k%128.
  function automatic logic [LANES*X_W-1:0] beat_data(input int mode, input int b);
    logic [LANES*X_W-1:0] d;
    d = '0;
    for (int l = 0; l < LANES; l++) begin
      d[l*X_W +: X_W] = (mode == 0) ? 7'd127 : 7'((b * LANES + l) % 128);
    end
    return d;
  endfunction

  // mode 0: all coefficients = val; mode 1: -3 on even k, 2 on odd k.
  task automatic load_theta(input int mode, input int val);
    for (int k = 0; k < N_FEAT; k++) begin
      theta_we   = 1'b1;
      theta_addr = A_W'(k);
      theta_data = (mode == 0) ? 16'(val) : ((k % 2 == 0) ? -16'sd3 : 16'sd2);
      @(posedge clk); #1;
    end
    theta_we = 1'b0;
  endtask

  task automatic send_beat(input int mode, input int b, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = beat_data(mode, b);
    in_last  = last;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept bound", (n < 50) ? 1 : 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vector(input int mode, input int first, input int count,
                             input int last_at, input bit gaps);
    for (int b = first; b < first + count; b++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
      send_beat(mode, b, (b == last_at));
    end
  endtask

  task automatic wait_result(input string tag, input int exp_h, input int exp_sat,
                             input int exp_fe);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " out_valid bound"}, (n < 30) ? 1 : 0, 1);
    check({tag, " hprime"}, hprime, exp_h);
    check({tag, " sat"}, sat, exp_sat);
    check({tag, " frame_err"}, frame_err, exp_fe);
    check({tag, " in_ready hold"}, in_ready, 0);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, " out_valid drop"}, out_valid, 0);
    end
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    theta_we   = 1'b0;
    theta_addr = '0;
    theta_data = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset hprime", hprime, 0);
    check("reset sat", sat, 0);
    check("reset frame_err", frame_err, 0);

    // Unit coefficients, x=127: 81*127 = 10287, with latency checks.
    load_theta(0, 1);
    send_vector(0, 0, 9, 8, 1'b0);
    check("t1 out_valid at t", out_valid, 0);
    @(posedge clk); #1;
    check("t1 out_valid at t+1", out_valid, 0);
    @(posedge clk); #1;
    check("t1 out_valid at t+2", out_valid, 1);
    wait_result("t1", 10287, 0, 0);

    // Positive and negative saturation at ACC_W=24.
    load_theta(0, 32767);
    send_vector(0, 0, 9, 8, 1'b0);
    wait_result("sat pos", 8388607, 1, 0);
    load_theta(0, -32768);
    send_vector(0, 0, 9, 8, 1'b0);
    wait_result("sat neg", -8388608, 1, 0);

    // Signed pattern, x[k]=k: 2*1600 - 3*1640 = -1720, without and with gaps.
    load_theta(1, 0);
    send_vector(1, 0, 9, 8, 1'b0);
    wait_result("signed", -1720, 0, 0);
    send_vector(1, 0, 9, 8, 1'b1);
    wait_result("signed gaps", -1720, 0, 0);

    // Early in_last on beat 5: features 0..53 -> 1458 - 2106 = -648.
    send_vector(1, 0, 6, 5, 1'b0);
    wait_result("early last", -648, 0, 1);
    // No in_last at all: vector closes at beat 8 and flags the framing error.
    send_vector(1, 0, 9, -1, 1'b0);
    wait_result("missing last", -1720, 0, 1);

    // Back-pressure, with coefficient writes attempted in ACCUM and HOLD.
    out_ready = 1'b0;
    send_vector(1, 0, 4, -1, 1'b0);
    theta_we   = 1'b1;
    theta_addr = A_W'(2);
    theta_data = 16'd555;
    @(posedge clk); #1;
    theta_we = 1'b0;
    send_vector(1, 4, 5, 8, 1'b0);
    wait_result("bp", -1720, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        theta_we   = 1'b1;
        theta_addr = A_W'(1);
        theta_data = 16'd555;
      end else begin
        theta_we = 1'b0;
      end
      @(posedge clk); #1;
      check("bp hprime stable", hprime, -1720);
      check("bp in_ready low", in_ready, 0);
      check("bp out_valid held", out_valid, 1);
    end
    theta_we  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release", out_valid, 0);
    send_vector(1, 0, 9, 8, 1'b0);
    wait_result("ignored writes", -1720, 0, 0);

    // Reset in the middle of a vector: abort, theta cleared.
    load_theta(0, 1);
    send_vector(0, 0, 4, -1, 1'b0);
    in_valid = 1'b1;
    in_data  = beat_data(0, 4);
    rst      = 1'b1;
    #1;
    check("midrst hprime", hprime, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst sat", sat, 0);
    check("midrst frame_err", frame_err, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        seen++;
      end
    end
    check("midrst no output", seen, 0);
    send_vector(0, 0, 9, 8, 1'b0);
    wait_result("post reset", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
